// File: rtl/seq_mac_arbiter.sv
// seq_mac_arbiter: round-robin sharing of one pipelined seq_MAC between NUM_REQ requesters.
// An in-order ID FIFO remembers who issued each job so results are steered back to that requester.
module seq_mac_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned M         = 1,
    parameter int unsigned N         = 1,
    parameter int unsigned K         = 1,
    parameter int unsigned MAX_WIDTH = 16,
    parameter int unsigned MAX_OUTST = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NUM_REQ-1:0]                req_valid_i,
    output logic [NUM_REQ-1:0]                req_ready_o,
    input  logic [NUM_REQ*M*K*MAX_WIDTH-1:0]  req_a_i,
    input  logic [NUM_REQ*K*N*MAX_WIDTH-1:0]  req_b_i,
    input  logic [NUM_REQ*M*N*32-1:0]         req_c_i,
    input  logic [NUM_REQ*5-1:0]              req_bsa_i,
    input  logic [NUM_REQ*5-1:0]              req_bsb_i,
    output logic [NUM_REQ-1:0]                rsp_valid_o,
    input  logic [NUM_REQ-1:0]                rsp_ready_i,
    output logic [M*N*32-1:0]                 rsp_d_o,
    output logic                              mac_valid_o,
    input  logic                              mac_ready_i,
    output logic [M*K*MAX_WIDTH-1:0]          mac_a_o,
    output logic [K*N*MAX_WIDTH-1:0]          mac_b_o,
    output logic [M*N*32-1:0]                 mac_c_o,
    output logic [4:0]                        mac_bsa_o,
    output logic [4:0]                        mac_bsb_o,
    input  logic                              mac_valid_i,
    output logic                              mac_ready_o,
    input  logic [M*N*32-1:0]                 mac_d_i,
    output logic [$clog2(MAX_OUTST):0]        outstanding_o
);

    localparam int unsigned AW  = M * K * MAX_WIDTH;
    localparam int unsigned BW  = K * N * MAX_WIDTH;
    localparam int unsigned CW  = M * N * 32;
    localparam int unsigned IW  = $clog2(NUM_REQ);
    localparam int unsigned IW1 = IW + 1;
    localparam int unsigned PW  = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int unsigned OW  = $clog2(MAX_OUTST) + 1;

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   lock_idx_q;
    logic [IW-1:0]   rr_ptr_q;
    logic [IW-1:0]   rr_ptr_d;
    logic [IW-1:0]   fifo_q [MAX_OUTST];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [OW-1:0]   count_q;
    logic [OW-1:0]   count_d;

    logic            grant_vld;
    logic [IW-1:0]   grant_idx;
    logic [IW:0]     cand_sum;
    logic [IW-1:0]   head_id;
    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
    endfunction

    assign fifo_full  = (count_q == OW'(MAX_OUTST));
    assign fifo_empty = (count_q == '0);
    assign head_id    = fifo_q[rd_ptr_q];

    // A LOCKED grant ignores new requests so mac_* data stays stable while the MAC stalls.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = lock_idx_q;
        cand_sum  = '0;
        if (state_q == LOCKED) begin
            grant_vld = ~fifo_full;
        end else if (!fifo_full) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                cand_sum = {1'b0, rr_ptr_q} + IW1'(i);
                if (cand_sum >= IW1'(NUM_REQ)) begin
                    cand_sum = cand_sum - IW1'(NUM_REQ);
                end
                if (!grant_vld && req_valid_i[cand_sum[IW-1:0]]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand_sum[IW-1:0];
                end
            end
        end
    end

    assign push = grant_vld & mac_ready_i & ~rst_i;
    assign pop  = mac_valid_i & mac_ready_o;

    assign rr_ptr_d = (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    assign mac_valid_o = grant_vld & ~rst_i;
    assign mac_a_o     = rst_i ? '0 : req_a_i[grant_idx*AW +: AW];
    assign mac_b_o     = rst_i ? '0 : req_b_i[grant_idx*BW +: BW];
    assign mac_c_o     = rst_i ? '0 : req_c_i[grant_idx*CW +: CW];
    assign mac_bsa_o   = rst_i ? '0 : req_bsa_i[grant_idx*5 +: 5];
    assign mac_bsb_o   = rst_i ? '0 : req_bsb_i[grant_idx*5 +: 5];

    always_comb begin
        req_ready_o = '0;
        if (push) begin
            req_ready_o[grant_idx] = 1'b1;
        end
    end

    assign mac_ready_o   = ~rst_i & ~fifo_empty & rsp_ready_i[head_id];
    assign rsp_d_o       = rst_i ? '0 : mac_d_i;
    assign outstanding_o = rst_i ? '0 : count_q;

    always_comb begin
        rsp_valid_o = '0;
        if (!rst_i && !fifo_empty && mac_valid_i) begin
            rsp_valid_o[head_id] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            lock_idx_q <= '0;
            rr_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            if (push) begin
                state_q          <= IDLE;
                rr_ptr_q         <= rr_ptr_d;
                fifo_q[wr_ptr_q] <= grant_idx;
                wr_ptr_q         <= wrap_inc(wr_ptr_q);
            end else if (mac_valid_o) begin
                state_q    <= LOCKED;
                lock_idx_q <= grant_idx;
            end
            if (pop) begin
                rd_ptr_q <= wrap_inc(rd_ptr_q);
            end
            count_q <= count_d;
        end
    end

    // A MAC result with no job on record means the MAC and arbiter disagree on what is in flight.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(mac_valid_i && fifo_empty));
        end
    end

endmodule

// File: tb/tb_seq_mac_arbiter.sv
// Bench for seq_mac_arbiter: a behavioural pipelined MAC plus per-requester expected-result queues.
module tb_seq_mac_arbiter;
    localparam int NR   = 4;
    localparam int MW   = 16;
    localparam int MAXO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NR-1:0]    req_valid, req_ready_o, rsp_valid_o, rsp_ready;
    logic [NR*MW-1:0] req_a, req_b;
    logic [NR*32-1:0] req_c;
    logic [NR*5-1:0]  req_bsa, req_bsb;
    logic [31:0]      rsp_d_o, mac_c_o, mac_d_i;
    logic             mac_valid_o, mac_ready_i, mac_valid_i, mac_ready_o;
    logic [MW-1:0]    mac_a_o, mac_b_o;
    logic [4:0]       mac_bsa_o, mac_bsb_o;
    logic [2:0]       outstanding_o;

    always #5 clk = ~clk;

    seq_mac_arbiter #(.NUM_REQ(NR), .M(1), .N(1), .K(1), .MAX_WIDTH(MW), .MAX_OUTST(MAXO)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready_o),
        .req_a_i(req_a), .req_b_i(req_b), .req_c_i(req_c),
        .req_bsa_i(req_bsa), .req_bsb_i(req_bsb),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready), .rsp_d_o(rsp_d_o),
        .mac_valid_o(mac_valid_o), .mac_ready_i(mac_ready_i),
        .mac_a_o(mac_a_o), .mac_b_o(mac_b_o), .mac_c_o(mac_c_o),
        .mac_bsa_o(mac_bsa_o), .mac_bsb_o(mac_bsb_o),
        .mac_valid_i(mac_valid_i), .mac_ready_o(mac_ready_o), .mac_d_i(mac_d_i),
        .outstanding_o(outstanding_o)
    );

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] c;
        logic [4:0]  bsa;
        logic [4:0]  bsb;
        logic [31:0] exp;
    } job_t;

    typedef struct packed {
        int          t;
        logic [31:0] d;
    } mac_ent_t;

    job_t        send_q [NR][$];
    logic [31:0] exp_q  [NR][$];
    int          order_q[$];
    int          gq[$];
    int          rq[$];
    mac_ent_t    pipe[$];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int out_m = 0;
    int mac_mode = 0;
    int rsp_mode = 0;
    int lat_fix = 0;
    logic [NR-1:0] rsp_blk = '0;
    logic [31:0]   last_d = '0;

    function automatic job_t mk_job(int a, int b, int c, int sa, int sb);
        job_t j;
        j.a   = 16'(a & ((1 << (2 * sa)) - 1));
        j.b   = 16'(b & ((1 << (2 * sb)) - 1));
        j.c   = 32'(c);
        j.bsa = 5'(sa);
        j.bsb = 5'(sb);
        j.exp = 32'(a * b + c);
        return j;
    endfunction

    function automatic int rand_val(int bits);
        return int'($urandom_range(0, (1 << bits) - 1)) - (1 << (bits - 1));
    endfunction

    function automatic int sext(logic [15:0] v, logic [4:0] bs);
        int bits = 2 * int'(bs);
        int x = int'(v) & ((1 << bits) - 1);
        if (bits > 0 && x >= (1 << (bits - 1))) x = x - (1 << bits);
        return x;
    endfunction

    function automatic bit busy();
        bit b = (order_q.size() != 0);
        for (int r = 0; r < NR; r++) if (send_q[r].size() != 0) b = 1'b1;
        return b;
    endfunction

    task automatic push_rand(int r, int sa, int sb);
        send_q[r].push_back(mk_job(rand_val(2 * sa), rand_val(2 * sb),
                                   int'($urandom_range(0, 1000)) - 500, sa, sb));
    endtask

    task automatic observe();
        logic [NR-1:0] exp_rv;
        logic          exp_mr;
        int            r;
        @(negedge clk);
        if (rst) return;
        n_chk++;
        if (outstanding_o !== 3'(out_m)) begin
            n_fail++;
            $display("FAIL outstanding: got %0d expected %0d", outstanding_o, out_m);
        end
        if (out_m == MAXO) begin
            n_chk++;
            if (mac_valid_o !== 1'b0 || req_ready_o !== '0) begin
                n_fail++;
                $display("FAIL full_stall: mac_valid_o=%b req_ready_o=%b expected 0/0", mac_valid_o, req_ready_o);
            end
        end
        exp_rv = '0;
        exp_mr = 1'b0;
        if (order_q.size() > 0) begin
            exp_mr = rsp_ready[order_q[0]];
            if (mac_valid_i) exp_rv[order_q[0]] = 1'b1;
        end
        n_chk++;
        if (rsp_valid_o !== exp_rv || mac_ready_o !== exp_mr) begin
            n_fail++;
            $display("FAIL rsp_steer: rsp_valid_o=%b mac_ready_o=%b expected %b/%b", rsp_valid_o, mac_ready_o, exp_rv, exp_mr);
        end
        n_chk++;
        if ((mac_valid_o && mac_ready_i) !== (req_ready_o != '0) || (req_ready_o & ~req_valid) != '0) begin
            n_fail++;
            $display("FAIL req_ready: req_ready_o=%b req_valid=%b mac_valid_o=%b mac_ready_i=%b",
                     req_ready_o, req_valid, mac_valid_o, mac_ready_i);
        end
        if (mac_valid_i && mac_ready_o && order_q.size() > 0) begin
            r = order_q.pop_front();
            n_chk++;
            if (rsp_d_o !== exp_q[r][0]) begin
                n_fail++;
                $display("FAIL rsp_data r%0d: got %0d expected %0d", r, $signed(rsp_d_o), $signed(exp_q[r][0]));
            end
            last_d = rsp_d_o;
            void'(exp_q[r].pop_front());
            void'(pipe.pop_front());
            out_m--;
            rq.push_back(r);
        end
        for (int i = 0; i < NR; i++) begin
            if (req_valid[i] && req_ready_o[i]) begin
                exp_q[i].push_back(send_q[i][0].exp);
                void'(send_q[i].pop_front());
                order_q.push_back(i);
                gq.push_back(i);
                out_m++;
            end
        end
        if (mac_valid_o && mac_ready_i) begin
            mac_ent_t e;
            e.t = cyc + ((lat_fix > 0) ? lat_fix : int'($urandom_range(1, 3)));
            e.d = 32'(sext(mac_a_o, mac_bsa_o) * sext(mac_b_o, mac_bsb_o) + int'(mac_c_o));
            pipe.push_back(e);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        cyc++;
        for (int r = 0; r < NR; r++) begin
            if (send_q[r].size() > 0) begin
                req_valid[r]          = 1'b1;
                req_a[r*MW +: MW]     = send_q[r][0].a;
                req_b[r*MW +: MW]     = send_q[r][0].b;
                req_c[r*32 +: 32]     = send_q[r][0].c;
                req_bsa[r*5 +: 5]     = send_q[r][0].bsa;
                req_bsb[r*5 +: 5]     = send_q[r][0].bsb;
            end else begin
                req_valid[r]          = 1'b0;
                req_a[r*MW +: MW]     = MW'($urandom);
                req_b[r*MW +: MW]     = MW'($urandom);
                req_c[r*32 +: 32]     = $urandom;
                req_bsa[r*5 +: 5]     = 5'($urandom);
                req_bsb[r*5 +: 5]     = 5'($urandom);
            end
            rsp_ready[r] = !rsp_blk[r] && (rsp_mode == 0 || (rsp_mode == 1 && $urandom_range(0, 1) == 1));
        end
        mac_ready_i = (mac_mode == 0) || (mac_mode == 1 && $urandom_range(0, 1) == 1);
        if (pipe.size() > 0 && pipe[0].t <= cyc) begin
            mac_valid_i = 1'b1;
            mac_d_i     = pipe[0].d;
        end else begin
            mac_valid_i = 1'b0;
            mac_d_i     = $urandom;
        end
    endtask

    task automatic tick();
        observe();
        advance();
    endtask

    task automatic drain(int budget);
        int n = 0;
        while (busy() && n < budget) begin
            tick();
            n++;
        end
        n_chk++;
        if (busy()) begin
            n_fail++;
            $display("FAIL drain: %0d jobs still in flight after %0d cycles, expected 0", order_q.size(), budget);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int r = 0; r < NR; r++) begin
            send_q[r].delete();
            exp_q[r].delete();
        end
        order_q.delete();
        pipe.delete();
        gq.delete();
        rq.delete();
        out_m = 0;
        mac_mode = 0;
        rsp_mode = 0;
        lat_fix = 0;
        rsp_blk = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        push_rand(0, 4, 4);
        push_rand(2, 3, 6);
        advance();
        #1;
        n_chk++;
        if (mac_valid_o !== 1'b0 || req_ready_o !== '0 || rsp_valid_o !== '0 || mac_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: mac_valid_o=%b req_ready_o=%b rsp_valid_o=%b mac_ready_o=%b expected all 0",
                     mac_valid_o, req_ready_o, rsp_valid_o, mac_ready_o);
        end
        n_chk++;
        if (mac_a_o !== '0 || mac_c_o !== '0 || rsp_d_o !== '0 || outstanding_o !== '0) begin
            n_fail++;
            $display("FAIL reset_data: mac_a_o=%h mac_c_o=%h rsp_d_o=%h outstanding_o=%0d expected 0",
                     mac_a_o, mac_c_o, rsp_d_o, outstanding_o);
        end
        rst = 1'b0;
        drain(100);
    endtask

    task automatic test_single();
        do_reset();
        send_q[0].push_back(mk_job(-455, 239, 0, 5, 5));
        tick();
        #1;
        n_chk++;
        if (mac_valid_o !== 1'b1 || mac_a_o !== 16'h0239 || mac_b_o !== 16'h00EF || mac_bsa_o !== 5'd5) begin
            n_fail++;
            $display("FAIL single_mux: valid=%b a=%h b=%h bsa=%0d expected 1/0239/00ef/5", mac_valid_o, mac_a_o, mac_b_o, mac_bsa_o);
        end
        drain(50);
        n_chk++;
        if (rq.size() != 1 || last_d !== 32'hFFFE5737) begin
            n_fail++;
            $display("FAIL single_result: responses=%0d data=%0d expected 1/-108745", rq.size(), $signed(last_d));
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int j = 0; j < 8; j++)
            for (int r = 0; r < NR; r++)
                push_rand(r, int'($urandom_range(1, 7)), int'($urandom_range(1, 7)));
        drain(600);
        n_chk++;
        if (gq.size() != 32) begin
            n_fail++;
            $display("FAIL rr_count: got %0d grants expected 32", gq.size());
        end
        for (int i = 0; i < gq.size() && i < 32; i++) begin
            n_chk++;
            if (gq[i] != i % NR) begin
                n_fail++;
                $display("FAIL rr_order[%0d]: got r%0d expected r%0d", i, gq[i], i % NR);
            end
        end
    endtask

    task automatic test_lock();
        do_reset();
        mac_mode = 2;
        push_rand(1, 4, 4);
        push_rand(2, 5, 3);
        tick();
        #1;
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (mac_valid_o !== 1'b1 || mac_a_o !== send_q[1][0].a || mac_c_o !== send_q[1][0].c) begin
                n_fail++;
                $display("FAIL lock_hold[%0d]: valid=%b a=%h c=%h expected 1/%h/%h",
                         k, mac_valid_o, mac_a_o, mac_c_o, send_q[1][0].a, send_q[1][0].c);
            end
            if (k == 0) push_rand(0, 2, 2);
            tick();
            #1;
        end
        mac_mode = 0;
        drain(100);
        n_chk++;
        if (gq.size() != 3 || gq[0] != 1 || gq[1] != 2 || gq[2] != 0) begin
            n_fail++;
            $display("FAIL lock_order: got %0d grants first r%0d expected r1,r2,r0", gq.size(), (gq.size() > 0) ? gq[0] : -1);
        end
    endtask

    task automatic test_full();
        do_reset();
        rsp_mode = 2;
        for (int r = 0; r < NR; r++)
            for (int j = 0; j < 3; j++) push_rand(r, 6, 6);
        repeat (12) tick();
        #1;
        n_chk++;
        if (outstanding_o !== 3'd4 || gq.size() != 4 || mac_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL full_count: outstanding_o=%0d accepted=%0d mac_valid_o=%b expected 4/4/0",
                     outstanding_o, gq.size(), mac_valid_o);
        end
        n_chk++;
        if (mac_valid_i !== 1'b1 || mac_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL full_backpressure: mac_valid_i=%b mac_ready_o=%b expected 1/0", mac_valid_i, mac_ready_o);
        end
        rsp_mode = 0;
        drain(200);
    endtask

    task automatic test_head_block();
        int n = 0;
        do_reset();
        rsp_blk = 4'b1000;
        push_rand(3, 7, 7);
        tick();
        push_rand(0, 3, 3);
        push_rand(1, 1, 2);
        while (!mac_valid_i && n < 20) begin
            tick();
            #1;
            n++;
        end
        n_chk++;
        if (mac_valid_i !== 1'b1) begin
            n_fail++;
            $display("FAIL head_wait: mac_valid_i=%b after %0d cycles expected 1", mac_valid_i, n);
        end
        for (int k = 0; k < 5; k++) begin
            n_chk++;
            if (mac_ready_o !== 1'b0 || rsp_valid_o !== 4'b1000) begin
                n_fail++;
                $display("FAIL head_block[%0d]: mac_ready_o=%b rsp_valid_o=%b expected 0/1000", k, mac_ready_o, rsp_valid_o);
            end
            tick();
            #1;
        end
        rsp_blk = '0;
        drain(100);
        n_chk++;
        if (rq.size() != 3 || rq[0] != 3) begin
            n_fail++;
            $display("FAIL head_first: %0d responses first r%0d expected 3 responses first r3", rq.size(), (rq.size() > 0) ? rq[0] : -1);
        end
    endtask

    task automatic test_reset_inflight();
        int n = 0;
        do_reset();
        lat_fix = 6;
        push_rand(0, 4, 4);
        push_rand(1, 4, 4);
        while (outstanding_o !== 3'd2 && n < 20) begin
            tick();
            #1;
            n++;
        end
        n_chk++;
        if (outstanding_o !== 3'd2) begin
            n_fail++;
            $display("FAIL inflight_setup: outstanding_o=%0d expected 2", outstanding_o);
        end
        rst = 1'b1;
        for (int r = 0; r < NR; r++) exp_q[r].delete();
        order_q.delete();
        pipe.delete();
        out_m = 0;
        lat_fix = 0;
        push_rand(1, 2, 5);
        push_rand(3, 5, 2);
        tick();
        #1;
        n_chk++;
        if (outstanding_o !== '0 || rsp_valid_o !== '0 || mac_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL inflight_reset: outstanding_o=%0d rsp_valid_o=%b mac_valid_o=%b expected 0/0/0",
                     outstanding_o, rsp_valid_o, mac_valid_o);
        end
        gq.delete();
        rst = 1'b0;
        drain(100);
        n_chk++;
        if (gq.size() != 2 || gq[0] != 1) begin
            n_fail++;
            $display("FAIL inflight_ptr: %0d grants first r%0d expected 2 grants first r1", gq.size(), (gq.size() > 0) ? gq[0] : -1);
        end
    endtask

    task automatic test_sweep();
        do_reset();
        mac_mode = 1;
        rsp_mode = 1;
        for (int sa = 1; sa <= 7; sa++)
            for (int sb = 1; sb <= 7; sb++)
                push_rand(int'($urandom_range(0, NR - 1)), sa, sb);
        drain(3000);
        n_chk++;
        if (rq.size() != 49) begin
            n_fail++;
            $display("FAIL sweep_count: got %0d responses expected 49", rq.size());
        end
    endtask

    initial begin
        req_valid   = '0;
        req_a       = '0;
        req_b       = '0;
        req_c       = '0;
        req_bsa     = '0;
        req_bsb     = '0;
        rsp_ready   = '0;
        mac_ready_i = 1'b0;
        mac_valid_i = 1'b0;
        mac_d_i     = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_lock();
        test_full();
        test_head_block();
        test_reset_inflight();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
